rca_slice_sequencer: RTL and testbench
======================================

// Module: rca_slice_sequencer
// PURPOSE
//  Multi-cycle controller that computes a wide sum (SLICE_W*NUM_SLICES bits) through one
//  shared SLICE_W-bit ripple-carry adder slice. The adder slice is instantiated outside this block.
//  Each cycle it presents one operand slice to the adder and latches the slice sum and carry.
//  Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.
// PARAMETERS
//  SLICE_W     16  width of the external RCA slice
//  NUM_SLICES  2   slices per operation; W = SLICE_W*NUM_SLICES (default 32)
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands a, b, cin are valid
//  in_ready   out  1        block can accept operands (IDLE only)
//  a          in   W        operand A
//  b          in   W        operand B
//  cin        in   1        carry-in to slice 0
//  slc_a      out  SLICE_W  A slice to external RCA
//  slc_b      out  SLICE_W  B slice to external RCA
//  slc_cin    out  1        carry-in to external RCA
//  slc_s      in   SLICE_W  RCA sum (combinational from slc_*)
//  slc_cout   in   1        RCA carry-out
//  out_valid  out  1        sum/cout/ovf valid
//  out_ready  in   1        consumer accepts result
//  sum        out  W        W-bit sum
//  cout       out  1        carry-out of MSB slice
//  ovf        out  1        two's-complement overflow
// BEHAVIOUR
//  FSM states: IDLE, RUN, DONE. Slice counter idx is $clog2(NUM_SLICES) bits wide (minimum 1).
//  Reset: state=IDLE, idx=0, carry_reg=0, sum_reg=0, cout=0, ovf=0, out_valid=0, in_ready=1,
//   slc_a=slc_b=0, slc_cin=0. Reset wins over every other event, including in the middle of RUN or DONE.
//  IDLE: in_ready=1. When in_valid=1, latch a, b and cin, set idx=0, and go to RUN.
//  RUN: in_ready=0.
//   slc_a = a_reg[idx*SLICE_W +: SLICE_W] and slc_b = b_reg[idx*SLICE_W +: SLICE_W].
//   slc_cin = (idx==0) ? cin_reg : carry_reg.
//   On each edge: sum_reg[idx slice] <= slc_s, carry_reg <= slc_cout, idx <= idx+1.
//   When idx==NUM_SLICES-1: go to DONE and set cout <= slc_cout.
//  DONE: out_valid=1, in_ready=0. sum, cout and ovf are held stable until out_ready=1.
//   The handshake completes in the cycle where out_valid && out_ready; the next cycle is IDLE.
//  Latency: operands accepted at edge T give out_valid=1 from edge T+NUM_SLICES
//   (this is NUM_SLICES RUN cycles). Maximum throughput is one op per NUM_SLICES+2 cycles.
//  ovf = (a_reg[W-1]==b_reg[W-1]) && (sum[W-1]!=a_reg[W-1]). Registered together with cout.
//  in_valid outside IDLE is ignored: operands are neither latched nor queued.
//  Changes on a/b while in RUN or DONE have no effect, because the latched copies are used.
//  slc_* outside RUN hold 0. The external RCA result is not sampled outside RUN.
//  sum is W bits and wraps modulo 2^W; the only record of bit W is cout.
//  NUM_SLICES=1 is legal: one RUN cycle, then DONE.
// TESTING
//  1. a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0, ovf=0.
//     out_valid asserts exactly 2 cycles after acceptance (checks the carry between slices).
//  2. a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0.
//     a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0, ovf=1.
//  3. Hold out_ready=0 for 5 cycles in DONE. Required: out_valid stays 1, sum/cout/ovf are stable,
//     in_ready=0. Then out_ready=1 for one cycle -> IDLE, and in_ready=1 on the next cycle.
//  4. Assert in_valid with a=0x12345678 while in RUN -> it is ignored.
//     The result matches the first operation only, and no second out_valid appears.
//  5. Assert rst=1 for one cycle in the first RUN cycle -> next cycle is IDLE with all outputs at
//     reset values. A fresh op 0x00000003+0x00000004 then gives sum=0x00000007.
//  6. 200 random a/b/cin with random out_ready backpressure -> every sum and cout equals {cout,sum}=a+b+cin.
//     Every ovf matches the signed-overflow model. Repeat with NUM_SLICES=4, SLICE_W=8.

Source files
------------

// File: rtl/rca_slice_sequencer_if.sv
// Operand/result handshake and external adder-slice bus of the slice sequencer.
// slave is the sequencer side; master is the operand producer, result consumer and adder slice.
interface rca_slice_sequencer_if #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 2
);
    localparam int W = SLICE_W * NUM_SLICES;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic               cin;
    logic [SLICE_W-1:0] slc_a;
    logic [SLICE_W-1:0] slc_b;
    logic               slc_cin;
    logic [SLICE_W-1:0] slc_s;
    logic               slc_cout;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       sum;
    logic               cout;
    logic               ovf;

    modport slave (
        input  in_valid, a, b, cin, slc_s, slc_cout, out_ready,
        output in_ready, slc_a, slc_b, slc_cin, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, slc_s, slc_cout, out_ready,
        input  in_ready, slc_a, slc_b, slc_cin, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_slice_sequencer.sv
// Computes a SLICE_W*NUM_SLICES-bit sum one slice per cycle through a shared external
// ripple-carry slice, with valid/ready handshakes on both the operand and result sides.
module rca_slice_sequencer #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rca_slice_sequencer_if.slave  bus
);
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [NUM_SLICES-1:0][SLICE_W-1:0] wide_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    wide_t            a_q, a_d;
    wide_t            b_q, b_d;
    wide_t            sum_q, sum_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Like-signed operands producing an opposite-signed result overflow.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cin_d   = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = bus.slc_s;
                carry_d      = bus.slc_cout;
                idx_d        = idx_q + 1'b1;
                // The last slice completes the word, so flags are taken from the merged sum.
                if (idx_q == LAST_IDX) begin
                    cout_d  = bus.slc_cout;
                    ovf_d   = signed_ovf(a_q[NUM_SLICES-1][SLICE_W-1],
                                         b_q[NUM_SLICES-1][SLICE_W-1],
                                         sum_d[NUM_SLICES-1][SLICE_W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.slc_a   = '0;
        bus.slc_b   = '0;
        bus.slc_cin = 1'b0;
        if (state_q == RUN) begin
            bus.slc_a   = a_q[idx_q];
            bus.slc_b   = b_q[idx_q];
            bus.slc_cin = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Directed and random bench for the slice sequencer: 16x2 instance plus an 8x4 instance,
// each paired with a behavioural ripple-carry slice.
module tb_rca_slice_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rca_slice_sequencer_if #(.SLICE_W(16), .NUM_SLICES(2)) bus0 ();
    rca_slice_sequencer_if #(.SLICE_W(8),  .NUM_SLICES(4)) bus1 ();

    rca_slice_sequencer #(.SLICE_W(16), .NUM_SLICES(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    rca_slice_sequencer #(.SLICE_W(8), .NUM_SLICES(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // External adder slices
    assign {bus0.slc_cout, bus0.slc_s} = {1'b0, bus0.slc_a} + {1'b0, bus0.slc_b} + {16'd0, bus0.slc_cin};
    assign {bus1.slc_cout, bus1.slc_s} = {1'b0, bus1.slc_a} + {1'b0, bus1.slc_b} + {8'd0, bus1.slc_cin};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                           output int lat, output logic [31:0] s, output logic co, output logic ov);
        bus0.a = a;
        bus0.b = b;
        bus0.cin = c;
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        s  = bus0.sum;
        co = bus0.cout;
        ov = bus0.ovf;
    endtask

    task automatic release_result();
        bus0.out_ready = 1'b1;
        step();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_handshake got %b want 10", {bus0.in_ready, bus0.out_valid});
        end
        checks++;
        if ({bus0.sum, bus0.cout, bus0.ovf} !== 34'd0) begin
            errors++; $display("FAIL reset_result got %h/%b/%b want 0/0/0", bus0.sum, bus0.cout, bus0.ovf);
        end
        checks++;
        if ({bus0.slc_a, bus0.slc_b, bus0.slc_cin} !== 33'd0) begin
            errors++; $display("FAIL reset_slice got %h/%h/%b want 0/0/0", bus0.slc_a, bus0.slc_b, bus0.slc_cin);
        end
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.sum} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL reset_dut1 got %b%b/%h want 10/0", bus1.in_ready, bus1.out_valid, bus1.sum);
        end
    endtask

    task automatic test_slice_carry();
        int lat; logic [31:0] s; logic co, ov;
        send_op(32'h0000FFFF, 32'h00000001, 1'b0, lat, s, co, ov);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL carry_latency got %0d want 2", lat); end
        checks++;
        if ({s, co, ov} !== {32'h00010000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL carry_sum got %h/%b/%b want 00010000/0/0", s, co, ov);
        end
        release_result();
    endtask

    task automatic test_boundaries();
        int lat; logic [31:0] s; logic co, ov;
        send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, s, co, ov);
        checks++;
        if ({s, co, ov} !== {32'h00000000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wrap_cout got %h/%b/%b want 00000000/1/0", s, co, ov);
        end
        release_result();
        send_op(32'h7FFFFFFF, 32'h00000000, 1'b1, lat, s, co, ov);
        checks++;
        if ({s, co, ov} !== {32'h80000000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ovf_cin got %h/%b/%b want 80000000/0/1", s, co, ov);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] s; logic co, ov;
        send_op(32'h11111111, 32'h22222222, 1'b0, lat, s, co, ov);
        checks++;
        if (s !== 32'h33333333) begin errors++; $display("FAIL hold_first got %h want 33333333", s); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus0.out_valid, bus0.in_ready, bus0.sum, bus0.cout, bus0.ovf} !== {2'b10, 32'h33333333, 2'b00}) begin
                errors++;
                $display("FAIL hold_cycle%0d got v=%b r=%b %h/%b/%b want v=1 r=0 33333333/0/0",
                         i, bus0.out_valid, bus0.in_ready, bus0.sum, bus0.cout, bus0.ovf);
            end
        end
        release_result();
        checks++;
        if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
            errors++; $display("FAIL hold_release got r=%b v=%b want r=1 v=0", bus0.in_ready, bus0.out_valid);
        end
    endtask

    task automatic test_ignore_in_run();
        int lat;
        bus0.a = 32'h00000001; bus0.b = 32'h00000002; bus0.cin = 1'b0; bus0.in_valid = 1'b1;
        step();
        bus0.a = 32'h12345678;
        step();
        bus0.in_valid = 1'b0;
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if ({bus0.out_valid, bus0.sum} !== {1'b1, 32'h00000003}) begin
            errors++; $display("FAIL ignore_sum got v=%b %h want v=1 00000003", bus0.out_valid, bus0.sum);
        end
        release_result();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
                errors++; $display("FAIL ignore_no_second%0d got v=%b r=%b want v=0 r=1", i, bus0.out_valid, bus0.in_ready);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [31:0] s; logic co, ov;
        bus0.a = 32'h00000005; bus0.b = 32'h00000006; bus0.cin = 1'b1; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        checks++;
        if ({bus0.slc_a, bus0.slc_b, bus0.slc_cin} !== {16'h0005, 16'h0006, 1'b1}) begin
            errors++; $display("FAIL run_slice0 got %h/%h/%b want 0005/0006/1", bus0.slc_a, bus0.slc_b, bus0.slc_cin);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus0.in_ready, bus0.out_valid, bus0.sum, bus0.cout, bus0.ovf,
             bus0.slc_a, bus0.slc_b, bus0.slc_cin} !== {2'b10, 67'd0}) begin
            errors++;
            $display("FAIL midrun_reset got r=%b v=%b %h/%b/%b slc=%h/%h/%b want r=1 v=0 all zero",
                     bus0.in_ready, bus0.out_valid, bus0.sum, bus0.cout, bus0.ovf,
                     bus0.slc_a, bus0.slc_b, bus0.slc_cin);
        end
        send_op(32'h00000003, 32'h00000004, 1'b0, lat, s, co, ov);
        checks++;
        if ({lat, s, co, ov} !== {32'd2, 32'h00000007, 2'b00}) begin
            errors++; $display("FAIL after_reset got lat=%0d %h/%b/%b want lat=2 00000007/0/0", lat, s, co, ov);
        end
        release_result();
    endtask

    task automatic test_random_16x2();
        int lat; logic [31:0] s; logic co, ov;
        logic [31:0] a, b; logic c; logic [32:0] full; logic exp_ovf;
        for (int n = 0; n < 200; n++) begin
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + {32'd0, c};
            exp_ovf = (a[31] == b[31]) && (full[31] != a[31]);
            send_op(a, b, c, lat, s, co, ov);
            checks++;
            if ({lat, co, s, ov} !== {32'd2, full, exp_ovf}) begin
                errors++;
                $display("FAIL rand16x2_%0d %h+%h+%b got lat=%0d %b/%h/%b want lat=2 %b/%h/%b",
                         n, a, b, c, lat, co, s, ov, full[32], full[31:0], exp_ovf);
            end
            repeat ($urandom_range(0, 3)) step();
            release_result();
        end
    endtask

    task automatic test_random_8x4();
        int lat; logic [31:0] a, b; logic c; logic [32:0] full; logic exp_ovf;
        for (int n = 0; n < 200; n++) begin
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + {32'd0, c};
            exp_ovf = (a[31] == b[31]) && (full[31] != a[31]);
            bus1.a = a; bus1.b = b; bus1.cin = c; bus1.in_valid = 1'b1;
            step();
            bus1.in_valid = 1'b0;
            lat = 0;
            while (bus1.out_valid !== 1'b1 && lat < 20) begin
                step();
                lat++;
            end
            checks++;
            if ({lat, bus1.cout, bus1.sum, bus1.ovf} !== {32'd4, full, exp_ovf}) begin
                errors++;
                $display("FAIL rand8x4_%0d %h+%h+%b got lat=%0d %b/%h/%b want lat=4 %b/%h/%b",
                         n, a, b, c, lat, bus1.cout, bus1.sum, bus1.ovf, full[32], full[31:0], exp_ovf);
            end
            repeat ($urandom_range(0, 3)) step();
            bus1.out_ready = 1'b1;
            step();
            bus1.out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_slice_carry();
        test_boundaries();
        test_backpressure();
        test_ignore_in_run();
        test_reset_mid_run();
        test_random_16x2();
        test_random_8x4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
